// File: rtl/aes128_pkg.sv
// Shared AES-128 types, constants and byte/word helpers.
package aes128_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (as a^254) followed by the affine map.
module aes_sbox
    import aes128_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0 and yields 0 for a == 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = gf_inv(in_i);
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: emits round keys 0..NR over a valid/ready handshake.
module aes128_key_sched
    import aes128_pkg::*;
#(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [KW-1:0] rk_out,
    output logic [3:0]    rk_idx,
    output logic          done
);

    localparam logic [3:0] IDX_LAST = 4'(NR);

    ks_state_t     state_q;
    logic          busy_q;
    logic          rk_valid_q;
    logic [KW-1:0] rk_out_q;
    logic [3:0]    rk_idx_q;
    logic          done_q;
    logic [7:0]    rcon_q;

    word_t         w0, w1, w2, w3;
    word_t         rot, sub, t;
    word_t         n0, n1, n2, n3;
    logic [KW-1:0] next_key_d;
    logic          accept;

    assign w0  = rk_out_q[127:96];
    assign w1  = rk_out_q[95:64];
    assign w2  = rk_out_q[63:32];
    assign w3  = rk_out_q[31:0];
    assign rot = rot_word(w3);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (rot[8*g +: 8]),
            .out_o (sub[8*g +: 8])
        );
    end

    assign t          = sub ^ {rcon_q, 24'h000000};
    assign n0         = w0 ^ t;
    assign n1         = w1 ^ n0;
    assign n2         = w2 ^ n1;
    assign n3         = w3 ^ n2;
    assign next_key_d = {n0, n1, n2, n3};
    assign accept     = rk_valid_q & rk_ready;

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_out_q   <= '0;
            rk_idx_q   <= 4'd0;
            done_q     <= 1'b0;
            rcon_q     <= RCON_INIT;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rk_out_q   <= key_in;
                        rk_idx_q   <= 4'd0;
                        rcon_q     <= RCON_INIT;
                        rk_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= EMIT;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (rk_idx_q == IDX_LAST) begin
                            rk_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            rk_out_q <= next_key_d;
                            rk_idx_q <= rk_idx_q + 4'd1;
                            // The last key consumes 8'h36; rcon stops there.
                            if (rk_idx_q != IDX_LAST - 4'd1) rcon_q <= xtime(rcon_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
    assign rk_idx   = rk_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes128_key_sched.sv
// Randomized bench for aes128_key_sched against a FIPS-197 style KeyExpansion model.
module tb_aes128_key_sched;

    logic         CLK = 1'b0;
    logic         RSTB;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    aes128_key_sched #(.NR(10), .KW(128)) dut (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference S-box built by walking the multiplicative group (p *= 3, q /= 3).
    logic [7:0] sbox_t [0:255];

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] rcon_of(input int i);
        case (i)
            0: return 8'h01;  1: return 8'h02;  2: return 8'h04;  3: return 8'h08;
            4: return 8'h10;  5: return 8'h20;  6: return 8'h40;  7: return 8'h80;
            8: return 8'h1B;  9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Textbook KeyExpansion over the 44-word array; returns round key idx.
    function automatic logic [127:0] key_at(input logic [127:0] k, input int idx);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rcon_of(i/4 - 1), 24'h000000};
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    // Transaction-level model: which key of which schedule is on offer.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_rst  = 1'b0;
    int           m_idx  = 0;
    logic [127:0] m_key  = '0;
    bit           chk_en = 1'b0;

    always @(posedge CLK) begin
        if (!RSTB) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_idx  = 0;
            m_rst  = 1'b1;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_key  = key_in;
                    m_idx  = 0;
                    m_busy = 1'b1;
                    m_rst  = 1'b0;
                end
            end else if (rk_ready) begin
                if (m_idx == 10) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", 128'(busy), 128'(m_busy));
            check("rk_valid", 128'(rk_valid), 128'(m_busy));
            check("done", 128'(done), 128'(m_done));
            if (m_busy) begin
                check("rk_idx", 128'(rk_idx), 128'(m_idx));
                check("rk_out", rk_out, key_at(m_key, m_idx));
            end else if (m_rst) begin
                check("rk_idx_rst", 128'(rk_idx), 128'(0));
                check("rk_out_rst", rk_out, 128'(0));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic run_sched(input string name, input bit rnd_ready, input int bound);
        bit got_done;
        got_done = 1'b0;
        for (int c = 0; c < bound; c++) begin
            rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        rk_ready = 1'b1;
        check(name, 128'(got_done), 128'(1));
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial begin
        logic [127:0] got1, got10, key_b;
        int  nvalid, cyc;
        bit  seen_done, prev_valid, stalled;

        RSTB     = 1'b0;
        start    = 1'b1;
        rk_ready = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        build_sbox();

        // Model pins against published values.
        check("sbox_00", 128'(sbox_t[8'h00]), 128'(8'h63));
        check("sbox_53", 128'(sbox_t[8'h53]), 128'(8'hED));
        check("model_fips_k1", key_at(FIPS_KEY, 1), FIPS_K1);
        check("model_fips_k10", key_at(FIPS_KEY, 10), FIPS_K10);
        check("model_zero_k1", key_at('0, 1), ZERO_K1);
        check("model_zero_k10", key_at('0, 10), ZERO_K10);

        // Reset held two cycles with start asserted: nothing may be emitted.
        tick();
        chk_en = 1'b1;
        tick();
        RSTB  = 1'b1;
        start = 1'b0;
        repeat (3) tick();

        // FIPS-197 A.1 with rk_ready tied high.
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        nvalid = 0; seen_done = 1'b0; prev_valid = 1'b0; cyc = 0;
        got1 = '0; got10 = '0;
        for (int c = 0; c < 60; c++) begin
            if (rk_valid) begin
                nvalid++;
                if (rk_idx == 4'd1)  got1  = rk_out;
                if (rk_idx == 4'd10) got10 = rk_out;
            end
            if (done) begin
                seen_done = 1'b1;
                cyc = c;
                check("done_follows_last", 128'(prev_valid), 128'(1));
                break;
            end
            prev_valid = rk_valid;
            tick();
        end
        check("fips_done_seen", 128'(seen_done), 128'(1));
        check("fips_valid_count", 128'(nvalid), 128'(11));
        check("fips_done_cycle", 128'(cyc), 128'(11));
        check("fips_k1", got1, FIPS_K1);
        check("fips_k10", got10, FIPS_K10);
        tick();
        check("done_one_cycle", 128'(done), 128'(0));

        // Same key with random backpressure and a 20-cycle stall at idx 5.
        start = 1'b1;
        tick();
        start = 1'b0;
        stalled = 1'b0; seen_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (rk_valid && rk_idx == 4'd5 && !stalled) begin
                rk_ready = 1'b0;
                repeat (20) tick();
                stalled = 1'b1;
            end
            rk_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        rk_ready = 1'b1;
        check("bp_done_seen", 128'(seen_done), 128'(1));
        check("bp_stall_hit", 128'(stalled), 128'(1));

        // All-zero key.
        key_in = '0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        got1 = 'x; got10 = 'x;
        for (int c = 0; c < 30 && !done; c++) begin
            if (rk_valid && rk_idx == 4'd1)  got1  = rk_out;
            if (rk_valid && rk_idx == 4'd10) got10 = rk_out;
            tick();
        end
        check("zero_k1", got1, ZERO_K1);
        check("zero_k10", got10, ZERO_K10);
        repeat (2) tick();

        // Starts while busy are ignored; start in the done cycle is taken.
        key_b  = {$urandom, $urandom, $urandom, $urandom};
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        key_in = key_b;
        start  = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            start = (rk_valid && (rk_idx == 4'd3 || rk_idx == 4'd10)) || done;
            if (done) begin
                seen_done = 1'b1;
                tick();
                break;
            end
            tick();
        end
        start = 1'b0;
        check("restart_done_seen", 128'(seen_done), 128'(1));
        check("restart_valid", 128'(rk_valid), 128'(1));
        check("restart_key0", rk_out, key_b);
        run_sched("restart_sched", 1'b1, 300);

        // Reset mid-stall at idx 6, then a fresh schedule.
        key_in = {$urandom, $urandom, $urandom, $urandom};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 200 && !(rk_valid && rk_idx == 4'd6); c++) begin
            rk_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rk_ready = 1'b0;
        check("rst_reached_idx6", 128'(rk_idx), 128'(6));
        repeat (3) tick();
        RSTB = 1'b0;
        tick();
        RSTB = 1'b1;
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out", rk_out, 128'(0));
        rk_ready = 1'b1;
        tick();
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("post_rst_k0", rk_out, FIPS_KEY);
        run_sched("post_rst_sched", 1'b0, 30);

        // Random keys, random backpressure, back-to-back starts.
        for (int s = 0; s < 6; s++) begin
            key_in = {$urandom, $urandom, $urandom, $urandom};
            start  = 1'b1;
            tick();
            start  = 1'b0;
            run_sched("rand_sched", 1'b1, 300);
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
